mem_responder: RTL

Memory responder serving the CPU pipeline's three memory interfaces: fetch read port, data read port and store write port. Every read returns one 16-bit word, two cycles after the word address is presented. Before the CPU runs, the block clears its storage and then accepts a host program-load stream. It raises `cpu_go` once loading completes and services CPU traffic from then on.

---
 rtl/mem_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory responder: clears storage, accepts a host program load, then serves CPU traffic.
// It has two 2-cycle read ports and one write port that the clear, load and store phases take turns to use.
module mem_responder #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    input  logic              ld_last,
    output logic              cpu_go,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [15:0]       rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [15:0]       rdata1,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Each phase owns the single write port, so storage needs only one write path.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        mem_we       = 1'b0;
        mem_waddr    = clr_cnt_reg;
        mem_wdata    = '0;
        ld_ready     = 1'b0;
        cpu_go       = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                if (clr_cnt_reg == '1) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_addr;
                    mem_wdata = ld_data;
                    if (ld_last) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cpu_go = 1'b1;
                if (wen) begin
                    mem_we    = 1'b1;
                    mem_waddr = waddr;
                    mem_wdata = wdata;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [ADDR_W-1:0] raddr_in [2];
    assign raddr_in[0] = raddr0;
    assign raddr_in[1] = raddr1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] raddr_reg;
            logic [15:0]       rdata_reg;

            // A write landing on the same edge as the array read is forwarded (write-first).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    raddr_reg <= '0;
                    rdata_reg <= '0;
                end else begin
                    raddr_reg <= raddr_in[gi];
                    rdata_reg <= (mem_we && (mem_waddr == raddr_reg)) ? mem_wdata : mem[raddr_reg];
                end
            end
        end
    endgenerate

    assign rdata0 = g_rd[0].rdata_reg;
    assign rdata1 = g_rd[1].rdata_reg;

endmodule
